// File: rtl/octagon_motion_ctrl.sv
// Frame-synchronous position/colour generator for the VGA octagon renderer.
// Auto-bounce or button-driven motion, with a host override word, all applied on rising vs_in.
module octagon_motion_ctrl #(
  parameter int         SPEED      = 4,
  parameter int         STEP       = 2,
  parameter int         X_LIM      = 255,
  parameter int         Y_LIM      = 188,
  parameter logic [7:0] COLOR_INIT = 8'hF0,
  parameter logic [7:0] COLOR_STEP = 8'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_color,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [31:0] position,
  output logic        frame_strobe
);

  localparam logic signed [10:0] XL = 11'(X_LIM);
  localparam logic signed [10:0] YL = 11'(Y_LIM);
  localparam logic signed [10:0] SP = 11'(SPEED);
  localparam logic signed [10:0] ST = 11'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, COMMIT = 2'd2} state_t;

  function automatic logic signed [10:0] sat_lim(input logic signed [10:0] v,
                                                 input logic signed [10:0] lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic signed [10:0] sm_to_int(input logic sgn, input logic [7:0] mag,
                                                   input logic signed [10:0] lim);
    logic signed [10:0] m;
    m = signed'({3'b000, mag});
    if (m > lim) m = lim;
    return sgn ? m : -m;
  endfunction

  // Zero maps to sign=1 so the renderer never sees a negative zero.
  function automatic logic [8:0] int_to_sm(input logic signed [9:0] v);
    logic signed [9:0] a;
    a = v[9] ? -v : v;
    return {~v[9], 8'(a)};
  endfunction

  state_t             state;
  logic               vs_d;
  logic [4:0]         btn_meta, btn_sync;
  logic               color_sync_d;
  logic               vld_p0, color_edge;
  logic               pending, use_cmd, color_pend, color_use, mode_l;
  logic [3:0]         btn_l;
  logic [25:0]        shadow;
  logic signed [9:0]  x, y;
  logic               dx_pos, dy_pos;
  logic [7:0]         colour;
  logic               cmd_unused;

  logic signed [10:0] xe, ye, sx, sy, nx, ny;
  logic               ndx, ndy, bounce;
  logic [7:0]         ncol, col_f;
  logic [8:0]         sm_x, sm_y;

  assign vld_p0     = vs_in & ~vs_d;
  assign color_edge = btn_sync[4] & ~color_sync_d;
  assign cmd_unused = ^cmd_data[29:24];

  // CALC stage: next position/direction/colour from the frame's latched inputs
  always_comb begin
    xe     = {x[9], x};
    ye     = {y[9], y};
    sx     = xe;
    sy     = ye;
    nx     = xe;
    ny     = ye;
    ndx    = dx_pos;
    ndy    = dy_pos;
    ncol   = colour;
    bounce = 1'b0;
    if (use_cmd) begin
      nx   = sm_to_int(shadow[25], shadow[23:16], XL);
      ny   = sm_to_int(shadow[24], shadow[15:8], YL);
      ncol = shadow[7:0];
    end else if (mode_l) begin
      sx = xe + (btn_l[3] ? ST : 11'sd0) - (btn_l[2] ? ST : 11'sd0);
      sy = ye + (btn_l[1] ? ST : 11'sd0) - (btn_l[0] ? ST : 11'sd0);
      nx = sat_lim(sx, XL);
      ny = sat_lim(sy, YL);
    end else begin
      sx = xe + (dx_pos ? SP : -SP);
      sy = ye + (dy_pos ? SP : -SP);
      if (sx >= XL) begin
        nx = XL;  ndx = 1'b0; bounce = 1'b1;
      end else if (sx <= -XL) begin
        nx = -XL; ndx = 1'b1; bounce = 1'b1;
      end else begin
        nx = sx;
      end
      if (sy >= YL) begin
        ny = YL;  ndy = 1'b0; bounce = 1'b1;
      end else if (sy <= -YL) begin
        ny = -YL; ndy = 1'b1; bounce = 1'b1;
      end else begin
        ny = sy;
      end
      if (bounce) ncol = colour + COLOR_STEP;
    end
  end

  // COMMIT stage: pending colour press and sign-magnitude packing
  assign col_f = colour + {7'd0, color_use};
  assign sm_x  = int_to_sm(x);
  assign sm_y  = int_to_sm(y);

  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) shadow <= {cmd_data[31:30], cmd_data[23:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      vs_d         <= 1'b1;  // no spurious tick if vs_in is already high at release
      btn_meta     <= '0;
      btn_sync     <= '0;
      color_sync_d <= 1'b0;
      pending      <= 1'b0;
      cmd_ready    <= 1'b1;
      use_cmd      <= 1'b0;
      color_pend   <= 1'b0;
      color_use    <= 1'b0;
      mode_l       <= 1'b0;
      btn_l        <= '0;
      x            <= '0;
      y            <= '0;
      dx_pos       <= 1'b1;
      dy_pos       <= 1'b1;
      colour       <= COLOR_INIT;
      position     <= {2'b11, 6'b0, 8'd0, 8'd0, COLOR_INIT};
      frame_strobe <= 1'b0;
    end else begin
      vs_d         <= vs_in;
      btn_meta     <= {btn_color, btn_right, btn_left, btn_down, btn_up};
      btn_sync     <= btn_meta;
      color_sync_d <= btn_sync[4];
      frame_strobe <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        pending   <= 1'b1;
        cmd_ready <= 1'b0;
      end
      if (color_edge) color_pend <= 1'b1;
      case (state)
        IDLE: if (vld_p0) begin
          state   <= CALC;
          mode_l  <= mode;
          btn_l   <= btn_sync[3:0];
          use_cmd <= pending;
          // The press being consumed leaves color_pend; a new edge this cycle stays pending.
          if (!pending) begin
            color_use  <= color_pend;
            color_pend <= color_edge;
          end else begin
            color_use  <= 1'b0;
          end
        end
        CALC: begin
          x      <= 10'(nx);
          y      <= 10'(ny);
          dx_pos <= ndx;
          dy_pos <= ndy;
          colour <= ncol;
          state  <= COMMIT;
        end
        COMMIT: begin
          colour       <= col_f;
          position     <= {sm_x[8], sm_y[8], 6'b0, sm_x[7:0], sm_y[7:0], col_f};
          frame_strobe <= 1'b1;
          if (use_cmd) begin
            pending   <= 1'b0;
            cmd_ready <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_octagon_motion_ctrl.sv
// Scoreboard bench for octagon_motion_ctrl: a behavioural model pushes the expected
// word at each tick; a monitor pops and compares on every frame_strobe.
module tb_octagon_motion_ctrl;

  localparam int SPEED = 4;
  localparam int STEP  = 2;
  localparam int X_LIM = 255;
  localparam int Y_LIM = 188;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b1;
  logic        mode = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_color = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready;
  logic [31:0] position;
  logic        frame_strobe;

  octagon_motion_ctrl dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .mode(mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_color(btn_color), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .position(position), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] pos;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int          m_x, m_y, m_dx, m_dy;
  logic [7:0]  m_col;
  bit          m_cmd, m_cpend;
  logic [31:0] m_shadow;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic int clampi(int v, int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic [31:0] mk_word(int x, int y, logic [7:0] c);
    logic [7:0] ax, ay;
    ax = 8'(x < 0 ? -x : x);
    ay = 8'(y < 0 ? -y : y);
    return {(x >= 0), (y >= 0), 6'b0, ax, ay, c};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    m_col = 8'hF0; m_cmd = 0; m_cpend = 0;
  endtask

  task automatic model_frame();
    int nx, ny, mg;
    bit b;
    exp_t e;
    if (m_cmd) begin
      mg = int'(m_shadow[23:16]); if (mg > X_LIM) mg = X_LIM;
      nx = m_shadow[31] ? mg : -mg;
      mg = int'(m_shadow[15:8]);  if (mg > Y_LIM) mg = Y_LIM;
      ny = m_shadow[30] ? mg : -mg;
      m_col = m_shadow[7:0];
      m_cmd = 0;
    end else begin
      if (mode) begin
        nx = m_x; if (btn_right) nx += STEP; if (btn_left) nx -= STEP;
        ny = m_y; if (btn_down)  ny += STEP; if (btn_up)   ny -= STEP;
        nx = clampi(nx, X_LIM);
        ny = clampi(ny, Y_LIM);
      end else begin
        b = 0;
        nx = m_x + m_dx * SPEED;
        ny = m_y + m_dy * SPEED;
        if (nx >= X_LIM)       begin nx = X_LIM;  m_dx = -1; b = 1; end
        else if (nx <= -X_LIM) begin nx = -X_LIM; m_dx = 1;  b = 1; end
        if (ny >= Y_LIM)       begin ny = Y_LIM;  m_dy = -1; b = 1; end
        else if (ny <= -Y_LIM) begin ny = -Y_LIM; m_dy = 1;  b = 1; end
        if (b) m_col = m_col + 8'h11;
      end
      if (m_cpend) begin m_col = m_col + 8'd1; m_cpend = 0; end
    end
    m_x = nx; m_y = ny;
    e.pos = mk_word(m_x, m_y, m_col);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (frame_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("position", position, mon_e.pos);
        check_val("strobe_latency", 32'(cyc - mon_e.cyc), 32'd3);
      end
    end
  end

  // One frame: vs_in low for a few cycles, then rising; optional command in the tick cycle.
  task automatic frame(input bit with_cmd, input logic [31:0] d);
    @(posedge clk); #1;
    vs_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vs_in = 1'b1;
    model_frame();
    if (with_cmd) begin
      cmd_data  = d;
      cmd_valid = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (with_cmd) begin m_cmd = 1; m_shadow = d; end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] d);
    @(posedge clk); #1;
    check_val("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_cmd = 1; m_shadow = d;
    check_val("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic press_color();
    @(posedge clk); #1;
    btn_color = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_color = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_cpend = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check_val("rst_position", position, 32'hC00000F0);
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;

    // Reset state, then stability with no tick
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check_val("idle_stable", position, 32'hC00000F0);

    // Auto bounce
    mode = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      frame(1'b0, 32'd0);
      if (i == 63) begin
        check_val("auto63_xmag", {24'd0, position[23:16]}, 32'd252);
        check_val("auto63_xsign", {31'd0, position[31]}, 32'd1);
      end
      if (i == 64) check_val("auto64_xmag", {24'd0, position[23:16]}, 32'd255);
      if (i == 65) check_val("auto65_xmag", {24'd0, position[23:16]}, 32'd251);
    end

    // Host override with y clamp
    send_cmd(32'h80C8FA5A);
    frame(1'b0, 32'd0);
    check_val("override_word", position, 32'h80C8BC5A);
    check_val("override_ready", {31'd0, cmd_ready}, 32'd1);
    frame(1'b0, 32'd0);

    // Colour press in auto mode
    press_color();
    frame(1'b0, 32'd0);

    // Command accepted in the tick cycle waits for the following tick
    frame(1'b1, 32'h40141E77);
    check_val("same_tick_ready", {31'd0, cmd_ready}, 32'd0);
    frame(1'b0, 32'd0);
    check_val("deferred_cmd", position, 32'h40141E77);

    // Manual mode
    do_reset();
    mode = 1'b1;
    btn_left = 1'b1;
    repeat (10) frame(1'b0, 32'd0);
    check_val("man_left_sign", {31'd0, position[31]}, 32'd0);
    check_val("man_left_mag", {24'd0, position[23:16]}, 32'd20);
    btn_left = 1'b0; btn_up = 1'b1; btn_down = 1'b1;
    repeat (5) frame(1'b0, 32'd0);
    check_val("man_updown_ymag", {24'd0, position[15:8]}, 32'd0);
    check_val("man_updown_ysign", {31'd0, position[30]}, 32'd1);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b1;
    repeat (200) frame(1'b0, 32'd0);
    check_val("man_left_sat", {24'd0, position[23:16]}, 32'd255);
    check_val("man_left_sat_sign", {31'd0, position[31]}, 32'd0);
    btn_left = 1'b0; btn_right = 1'b1; btn_down = 1'b1;
    press_color();
    repeat (3) frame(1'b0, 32'd0);
    btn_right = 1'b0; btn_down = 1'b0;

    // Reset during CALC with a pending command and colour press
    mode = 1'b0;
    send_cmd(32'h00112233);
    press_color();
    @(posedge clk); #1;
    vs_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vs_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check_val("midcalc_rst_pos", position, 32'hC00000F0);
    check_val("midcalc_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    frame(1'b0, 32'd0);
    check_val("post_rst_auto", position, 32'hC00404F0);

    repeat (5) @(posedge clk);
    #1;
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
